// File: rtl/core_run_ctrl.sv
// core_run_ctrl: boot and run sequencer for the single-cycle RISC-V core.
// Streams a program into instruction memory while the core is held in
// reset, releases the core, and stops it again on ECALL/EBREAK.
// Optional feature macro: CYCLE_LIMIT_EN adds a MAX_CYCLES run budget that
// forces a halt with timeout=1. Without it timeout is 0 and cycle_cnt wraps.

module core_run_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int MAX_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ld_valid,
   input  logic [31:0]       ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   input  logic [31:0]       core_instr,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [31:0]       cycle_cnt,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_RUN,
      S_HALT
   } state_t;

   localparam logic [31:0]       INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0]       INSTR_EBREAK = 32'h0010_0073;
   localparam logic [ADDR_W-1:0] PTR_LAST     = {ADDR_W{1'b1}};
   localparam logic [31:0]       BUDGET_LAST  = 32'(MAX_CYCLES - 1);

`ifdef CYCLE_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic [31:0]       cycle_q, cycle_d;
   logic              timeout_q, timeout_d;
   logic              ld_ready_q, ld_ready_d;
   logic              core_rst_n_q, core_rst_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic handshake;
   logic halt_instr;
   logic budget_hit;

   // Write port is combinational so a word lands in memory in its handshake cycle.
   always_comb begin
      handshake  = (state_q == S_LOAD) && ld_valid;
      halt_instr = (core_instr == INSTR_ECALL) || (core_instr == INSTR_EBREAK);
      budget_hit = LIMIT_EN && (cycle_q == BUDGET_LAST);
      imem_we    = handshake;
      imem_addr  = ptr_q;
      imem_wdata = ld_data;
   end

   // Next-state logic; status outputs are derived from the next state so they are registered.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      words_d   = words_q;
      cycle_d   = cycle_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d   = S_LOAD;
               ptr_d     = '0;
               words_d   = '0;
               cycle_d   = '0;
               timeout_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (handshake) begin
               words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
               if (ptr_q != PTR_LAST) begin
                  ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
               if (ld_last || (ptr_q == PTR_LAST)) begin
                  state_d = S_ARM;
               end
            end
         end
         S_ARM: begin
            cycle_d = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cycle_d = cycle_q + 32'd1;
            if (halt_instr) begin
               state_d = S_HALT;
            end else if (budget_hit) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ld_ready_d   = (state_d == S_LOAD);
      core_rst_n_d = (state_d == S_RUN);
      busy_d       = (state_d == S_LOAD) || (state_d == S_ARM) || (state_d == S_RUN);
      done_d       = (state_d == S_HALT);
   end

   // Sequencer state and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         words_q      <= '0;
         cycle_q      <= '0;
         timeout_q    <= 1'b0;
         ld_ready_q   <= 1'b0;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         words_q      <= words_d;
         cycle_q      <= cycle_d;
         timeout_q    <= timeout_d;
         ld_ready_q   <= ld_ready_d;
         core_rst_n_q <= core_rst_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ld_ready     = ld_ready_q;
   assign core_rst_n   = core_rst_n_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign timeout      = timeout_q;
   assign cycle_cnt    = cycle_q;
   assign words_loaded = words_q;

endmodule
